// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Opcodes, FSM encoding and helpers shared by alu_ext and muldiv_iter
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_SLL  = 4'd4;
    localparam logic [3:0] OP_SRL  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;
    localparam logic [3:0] OP_MULH = 4'd10;
    localparam logic [3:0] OP_DIV  = 4'd11;
    localparam logic [3:0] OP_DIVU = 4'd12;
    localparam logic [3:0] OP_REM  = 4'd13;
    localparam logic [3:0] OP_REMU = 4'd14;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_iter.sv
// ============================================================================
// Module : muldiv_iter
// Brief  : Radix-2 iterative multiply / restoring divide datapath with sign fix
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] res_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opb_q;
    logic [WIDTH-1:0]   a_q;
    logic [3:0]         op_q;
    logic               negq_q;
    logic               negr_q;
    logic               div0_q;
    logic               ovf_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               w_signed;
    logic               w_is_mul;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_div_q;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_signed = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    assign w_is_mul = (op_i == OP_MUL) || (op_i == OP_MULH);
    assign w_mag_a  = (w_signed && a_i[WIDTH-1]) ? -a_i : a_i;
    assign w_mag_b  = (w_signed && b_i[WIDTH-1]) ? -b_i : b_i;
    assign w_div_q  = (op_q != OP_MUL) && (op_q != OP_MULH);

    // Multiplier bits live in the low half of acc and are consumed from bit 0.
    assign w_sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
    assign w_mul_next = {w_sum, acc_q[WIDTH-1:1]};

    // Remainder in the high half, dividend shifting out of / quotient into the low half.
    assign w_shift    = acc_q[2*WIDTH-1:WIDTH-1];
    assign w_diff     = w_shift - {1'b0, opb_q};
    assign w_div_next = w_diff[WIDTH] ? {w_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                      : {w_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

    assign last_o = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            opb_q  <= '0;
            a_q    <= '0;
            op_q   <= OP_AND;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            div0_q <= 1'b0;
            ovf_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (load_i) begin
            acc_q  <= {{WIDTH{1'b0}}, (w_is_mul ? w_mag_b : w_mag_a)};
            opb_q  <= w_is_mul ? w_mag_a : w_mag_b;
            a_q    <= a_i;
            op_q   <= op_i;
            negq_q <= w_signed && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            negr_q <= w_signed && a_i[WIDTH-1];
            div0_q <= (b_i == '0);
            ovf_q  <= w_signed && !w_is_mul && (a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (b_i == '1);
            cnt_q  <= '0;
        end else if (step_i) begin
            acc_q <= w_div_q ? w_div_next : w_mul_next;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign w_prod = negq_q ? -acc_q : acc_q;
    assign w_quo  = negq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign w_rem  = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        res_o = '0;
        case (op_q)
            OP_MUL:  res_o = w_prod[WIDTH-1:0];
            OP_MULH: res_o = w_prod[2*WIDTH-1:WIDTH];
            OP_DIV:  res_o = div0_q ? '1 : (ovf_q ? a_q : w_quo);
            OP_DIVU: res_o = div0_q ? '1 : w_quo;
            OP_REM:  res_o = div0_q ? a_q : (ovf_q ? '0 : w_rem);
            OP_REMU: res_o = div0_q ? a_q : w_rem;
            default: res_o = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_ext.sv
// ============================================================================
// Module : alu_ext
// Brief  : Execute-stage ALU, single-cycle logic/arith plus iterative MUL/DIV
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_ext
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       aluctrl,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             out_valid_q, out_valid_d;

    logic             w_accept;
    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_alu;
    logic [WIDTH-1:0] w_md;

    assign in_ready = (state_q == S_IDLE);
    assign busy     = !in_ready;
    assign w_accept = in_valid && in_ready && !flush;
    assign w_load   = w_accept && is_muldiv(aluctrl);
    assign w_step   = (state_q == S_CALC) && !flush;
    assign w_shamt  = in2[SHW-1:0];

    always_comb begin
        w_alu = '0;
        case (aluctrl)
            OP_AND:  w_alu = in1 & in2;
            OP_OR:   w_alu = in1 | in2;
            OP_ADD:  w_alu = in1 + in2;
            OP_XOR:  w_alu = in1 ^ in2;
            OP_SLL:  w_alu = in1 << w_shamt;
            OP_SRL:  w_alu = in1 >> w_shamt;
            OP_SUB:  w_alu = in1 - in2;
            OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
            OP_SRA:  w_alu = $unsigned($signed(in1) >>> w_shamt);
            default: w_alu = '0;
        endcase
    end

    muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (w_load),
        .step_i (w_step),
        .op_i   (aluctrl),
        .a_i    (in1),
        .b_i    (in2),
        .last_o (w_last),
        .res_o  (w_md)
    );

    // Flush wins over everything; a squashed op leaves result/zero untouched.
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        zero_d      = zero_q;
        out_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (is_muldiv(aluctrl)) begin
                        state_d = S_CALC;
                    end else begin
                        result_d    = w_alu;
                        zero_d      = (w_alu == '0);
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_CALC: begin
                if (flush)       state_d = S_IDLE;
                else if (w_last) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!flush) begin
                    result_d    = w_md;
                    zero_d      = (w_md == '0);
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            result_q    <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result    = result_q;
    assign zero      = zero_q;
    assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_ext.sv
// ============================================================================
// Module : tb_alu_ext
// Brief  : Scoreboard bench for alu_ext (WIDTH=64)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_ext;
    import alu_pkg::*;

    localparam int W = 64;
    localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         flush = 1'b0;
    logic [3:0]   aluctrl = 4'd0;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic         in_ready, out_valid, zero, busy;
    logic [W-1:0] result;

    int           n_chk = 0;
    int           n_pass = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;

    alu_ext #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluctrl   (aluctrl),
        .in1       (in1),
        .in2       (in2),
        .flush     (flush),
        .out_valid (out_valid),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
    endtask

    function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W-1:0]   sa, sb;
        logic signed [2*W-1:0] ea, eb, p;
        logic [5:0]            sh;
        sa = a; sb = b; sh = b[5:0];
        ea = {{W{a[W-1]}}, a};
        eb = {{W{b[W-1]}}, b};
        p  = ea * eb;
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_ADD:  return a + b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << sh;
            OP_SRL:  return a >> sh;
            OP_SUB:  return a - b;
            OP_SLT:  return (sa < sb) ? 64'd1 : 64'd0;
            OP_SRA:  return $unsigned(sa >>> sh);
            OP_MUL:  return a * b;
            OP_MULH: return p[2*W-1:W];
            OP_DIV:  return (b == 0) ? '1 : ((a == MINV && b == '1) ? a : $unsigned(sa / sb));
            OP_DIVU: return (b == 0) ? '1 : a / b;
            OP_REM:  return (b == 0) ? a : ((a == MINV && b == '1) ? '0 : $unsigned(sa % sb));
            OP_REMU: return (b == 0) ? a : a % b;
            default: return '0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("result", result, mon_e);
                chk("zero", 64'(zero), 64'(mon_e == '0));
            end
        end
    end

    // Called at posedge+1; acceptance happens at the next edge.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push, input logic [W-1:0] e);
        in_valid = 1'b1;
        aluctrl  = op;
        in1      = a;
        in2      = b;
        if (push) exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int exp_lat);
        int n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 64'(n), 64'(exp_lat));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]   rop;
        logic [W-1:0] ra, rb;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_zero", 64'(zero), 64'd1);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back single-cycle ops
        issue(OP_ADD, 64'd5, -64'sd7, 1, -64'sd2);
        chk("b2b_ov1", 64'(out_valid), 64'd1);
        issue(OP_SUB, 64'd3, 64'd3, 1, 64'd0);
        chk("b2b_ov2", 64'(out_valid), 64'd1);
        chk("b2b_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        chk("ov_pulse", 64'(out_valid), 64'd0);

        // Multiply
        issue(OP_MUL, -64'sd3, 64'd7, 1, -64'sd21);
        chk("mul_busy", 64'(busy), 64'd1);
        wait_done(W + 1);
        chk("mul_ready_done", 64'(in_ready), 64'd1);
        issue(OP_MULH, -64'sd3, 64'd7, 1, '1);
        wait_done(W + 1);

        // Division and corner cases
        issue(OP_DIV, -64'sd20, 64'd3, 1, -64'sd6);  wait_done(W + 1);
        issue(OP_REM, -64'sd20, 64'd3, 1, -64'sd2);  wait_done(W + 1);
        issue(OP_DIVU, 64'd20, 64'd0, 1, '1);        wait_done(W + 1);
        issue(OP_REM, 64'd20, 64'd0, 1, 64'd20);     wait_done(W + 1);
        issue(OP_DIV, MINV, '1, 1, MINV);            wait_done(W + 1);
        issue(OP_REM, MINV, '1, 1, 64'd0);           wait_done(W + 1);

        // Flush in CALC cycle 10
        issue(OP_ADD, 64'd1, 64'd2, 1, 64'd3);
        issue(OP_DIV, 64'd100, 64'd7, 0, '0);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_ov", 64'(out_valid), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        chk("flush_result", result, 64'd3);
        issue(OP_ADD, 64'd10, 64'd20, 1, 64'd30);
        chk("post_flush_ov", 64'(out_valid), 64'd1);
        repeat (W + 5) begin @(posedge clk); #1; end

        // Flush in IDLE with simultaneous single-cycle request
        in_valid = 1'b1; flush = 1'b1; aluctrl = OP_ADD; in1 = 64'd1; in2 = 64'd1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("idle_flush_ov", 64'(out_valid), 64'd0);
        chk("idle_flush_result", result, 64'd30);

        // New request while busy is ignored
        issue(OP_MUL, 64'd6, 64'd7, 1, 64'd42);
        in_valid = 1'b1; aluctrl = OP_ADD; in1 = 64'd1; in2 = 64'd1;
        repeat (5) begin @(posedge clk); #1; end
        chk("busy_not_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        wait_done(W + 1 - 5);

        // Async reset mid-CALC
        issue(OP_DIV, 64'd50, 64'd5, 0, '0);
        repeat (5) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ov", 64'(out_valid), 64'd0);
        chk("arst_result", result, 64'd0);
        chk("arst_zero", 64'(zero), 64'd1);
        chk("arst_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Shift / compare / undefined opcode
        issue(OP_SRA, MINV, 64'h43, 1, 64'hF000_0000_0000_0000);
        issue(OP_SLT, '1, 64'd1, 1, 64'd1);
        issue(4'd15, 64'd123, 64'd456, 1, 64'd0);
        issue(OP_SLL, 64'h1, 64'h7F, 1, MINV);

        // Randomised mix checked against the reference model
        for (int i = 0; i < 24; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = {$urandom, $urandom};
            rb  = (i % 6 == 5) ? 64'd0 : ((i % 3 == 0) ? 64'($urandom_range(1, 1000)) : {$urandom, $urandom});
            issue(rop, ra, rb, 1, model(rop, ra, rb));
            if (is_muldiv(rop)) wait_done(W + 1);
        end

        repeat (3) begin @(posedge clk); #1; end
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_ext.md
Name: alu_ext

Overview:
Parametrised successor to the single-cycle execute-stage ALU. Keeps the AND/OR/ADD/SUB encodings and adds XOR, shifts, set-less-than and RV64M-style multiply/divide/remainder. Logic ops complete in one cycle. MUL/DIV run on an iterative datapath with an in_valid/in_ready handshake. The EX stage stalls on busy and is released by out_valid.

Parameters:
WIDTH, 64, operand and result width in bits (must be even, ≥8)
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clk      input   1        clock, rising edge
rst_n    input   1        reset, asynchronous, active-low
in_valid input   1        operation request
in_ready output  1        block can accept a request this cycle
aluctrl  input   4        opcode
in1      input   WIDTH    operand A (signed interpretation unless op is unsigned)
in2      input   WIDTH    operand B
flush    input   1        abort current op (pipeline squash)
out_valid output 1        one-cycle pulse: result is valid
result   output  WIDTH    registered result, held until next completion
zero     output  1        registered (result == 0)
busy     output  1        multi-cycle op in progress

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_valid=0, result=0, zero=1, busy=0, in_ready=1, counter=0.
- Opcodes:
  - 0 AND, 1 OR, 2 ADD, 3 XOR, 4 SLL, 5 SRL.
  - 6 SUB, 7 SLT (signed, result 1/0), 8 SRA.
  - 9 MUL (low WIDTH bits), 10 MULH (signed×signed, high WIDTH bits).
  - 11 DIV, 12 DIVU, 13 REM, 14 REMU, 15 undefined.
- Shift amount is in2[$clog2(WIDTH)-1:0]; upper bits are ignored.
- Undefined opcode: result=0, single-cycle path.
- Acceptance: the edge where in_valid && in_ready && !flush.
- in_ready = (state==IDLE); busy = !in_ready.
- Single-cycle ops: result/zero registered at the acceptance edge; out_valid=1 for the following cycle. State stays IDLE, so back-to-back issue gives throughput 1/cycle.
- MUL/DIV FSM: IDLE -> CALC -> FIX -> IDLE.
  - IDLE->CALC on acceptance. Latch operand magnitudes and result sign; counter=0.
  - CALC: one radix-2 shift-add (MUL) or restoring shift-subtract (DIV) step per cycle. Exit to FIX after exactly WIDTH steps; there is no early exit.
  - FIX: apply sign correction and select the low/high half or quotient/remainder. Register result/zero; pulse out_valid; return to IDLE.
  - Fixed latency: out_valid is high in the cycle after edge k+WIDTH+1, where edge k is acceptance. in_ready rises in that same cycle.
- Division corner cases (fixed latency still applies):
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU remainder = in1.
  - Signed overflow (in1 = most-negative, in2 = -1): DIV = in1, REM = 0.
- Width rule: MUL product is held internally at 2*WIDTH bits and two's-complemented in FIX when the result sign is set.
- Flush:
  - In CALC or FIX: return to IDLE on the next edge, no out_valid, result/zero unchanged.
  - In IDLE: blocks acceptance in that cycle and suppresses out_valid for a simultaneous single-cycle op.
  - Flush has priority over in_valid.
- in_valid while busy is ignored (in_ready=0); the upstream holds its operands.
- Reset mid-operation: immediate return to reset values; the partial result is discarded.
- out_valid never stays high for more than one cycle per accepted op.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams (OP_AND=0 … OP_REMU=14)
  - FSM state encoding (IDLE/CALC/FIX)
  - an is_muldiv(op) function
- Sub-module muldiv_iter holds the CALC datapath: accumulator, shift registers, counter, sign fix. alu_ext holds the single-cycle ops, handshake, FSM control and output registers.

Test Plan:
- ADD 5+(-7), then SUB 3-3 back-to-back -> out_valid on consecutive cycles, result=-2 then 0 with zero=1; in_ready stays 1.
- MUL in1=-3, in2=7 (WIDTH=64) -> busy for 65 cycles, out_valid once at the cycle after edge k+65, result=-21. MULH on the same operands -> all ones.
- DIV -20/3 -> result=-6; REM -20/3 -> -2; DIVU 20/0 -> all ones; REM 20/0 -> 20; DIV 0x8000…0 / -1 -> 0x8000…0; REM of that -> 0.
- Start DIV, assert flush at CALC cycle 10 -> no out_valid, in_ready=1 next cycle, result keeps its previous value; a new ADD is accepted immediately.
- in_valid with a new op while busy -> ignored; drop rst_n mid-CALC -> out_valid=0, result=0, zero=1, in_ready=1 asynchronously.
- SRA in1=0x8000…0, in2=0x43 (shift 3) -> 0xF000…0; SLT -1<1 -> 1; aluctrl=15 -> result 0, zero=1.
